load_store_unit: RTL and testbench

- Memory stage directly downstream of the ALU.
- Takes the ALU result as the effective address and the rt register value as store data.
- Runs one byte, halfword or word transaction on a req/ack data-memory bus that may insert wait states.
- Stalls the core until the access completes, then returns the aligned, extended load value for writeback.

---
 rtl/ls_pkg.sv | 26 ++
 rtl/ls_lane_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size
// codes and the alignment check used when an access is accepted.
package ls_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 2'b11 is handled exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lo[0];
            default: m = (lo != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Combinational byte-lane steering: store-side byte enables and replicated
// write data, and load-side lane selection with sign/zero extension.
module ls_lane_align
    import ls_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: enables follow the little-endian lane, data is replicated.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: pick the lane, then extend to 32 bits.
    always_comb begin
        byte_s     = 8'h00;
        half_s     = 16'h0000;
        load_value = rdata;
        case (lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SZ_BYTE: load_value = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_value = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: runs one byte/half/word access on a req/ack bus with optional
// wait-state timeout, stalls the core meanwhile and returns the extended load data.
module load_store_unit
    import ls_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        ls_done,
    output logic [31:0] load_result,
    output logic        addr_misaligned,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t             state_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [1:0]         size_r;
    logic [1:0]         lane_r;
    logic               uns_r;
    logic               write_r;

    logic               accept_s;
    logic               misaligned_s;
    logic               tmo_hit_s;
    logic [1:0]         sel_size_s;
    logic [1:0]         sel_lane_s;
    logic               sel_uns_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_s;
    logic [31:0]        load_value_s;

    assign accept_s     = ls_valid & (mem_read | mem_write);
    assign misaligned_s = is_misaligned(ls_size, alu_addr[1:0]);
    assign stall        = rst_n & (((state_r == IDLE) & accept_s) | (state_r == WAIT));
    // Timeout fires on the WAIT cycle whose increment would reach the limit.
    assign tmo_hit_s    = (TIMEOUT_CYCLES != 0) &&
                          ((tmo_cnt_r + TMO_W'(1)) == TMO_W'(TIMEOUT_CYCLES));

    // Lane aligner sees live inputs at accept time and the latched access afterwards.
    always_comb begin
        sel_size_s = size_r;
        sel_lane_s = lane_r;
        sel_uns_s  = uns_r;
        if (state_r == IDLE) begin
            sel_size_s = ls_size;
            sel_lane_s = alu_addr[1:0];
            sel_uns_s  = ls_unsigned;
        end else begin
            sel_size_s = size_r;
            sel_lane_s = lane_r;
            sel_uns_s  = uns_r;
        end
    end

    ls_lane_align u_align (
        .size        (sel_size_s),
        .lo          (sel_lane_s),
        .is_unsigned (sel_uns_s),
        .store_data  (store_data),
        .rdata       (bus_rdata),
        .be          (be_s),
        .wdata       (wdata_s),
        .load_value  (load_value_s)
    );

    // Access FSM with timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            tmo_cnt_r       <= '0;
            size_r          <= 2'b00;
            lane_r          <= 2'b00;
            uns_r           <= 1'b0;
            write_r         <= 1'b0;
            ls_done         <= 1'b0;
            load_result     <= 32'h0000_0000;
            addr_misaligned <= 1'b0;
            bus_error       <= 1'b0;
            bus_req         <= 1'b0;
            bus_we          <= 1'b0;
            bus_addr        <= 32'h0000_0000;
            bus_be          <= 4'h0;
            bus_wdata       <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        size_r  <= ls_size;
                        lane_r  <= alu_addr[1:0];
                        uns_r   <= ls_unsigned;
                        write_r <= mem_write;
                        if (misaligned_s) begin
                            state_r         <= DONE;
                            ls_done         <= 1'b1;
                            addr_misaligned <= 1'b1;
                            load_result     <= 32'h0000_0000;
                        end else begin
                            state_r   <= WAIT;
                            tmo_cnt_r <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {alu_addr[31:2], 2'b00};
                            bus_be    <= be_s;
                            bus_wdata <= mem_write ? wdata_s : 32'h0000_0000;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        state_r     <= DONE;
                        bus_req     <= 1'b0;
                        ls_done     <= 1'b1;
                        load_result <= write_r ? 32'h0000_0000 : load_value_s;
                    end else if (tmo_hit_s) begin
                        state_r     <= DONE;
                        tmo_cnt_r   <= tmo_cnt_r + TMO_W'(1);
                        bus_req     <= 1'b0;
                        ls_done     <= 1'b1;
                        bus_error   <= 1'b1;
                        load_result <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                DONE: begin
                    state_r         <= IDLE;
                    ls_done         <= 1'b0;
                    addr_misaligned <= 1'b0;
                    bus_error       <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; a second instance with a
// short timeout covers the bus_error path and the ack-versus-timeout race.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, t_valid;
    logic        mem_read, mem_write, ls_unsigned;
    logic [1:0]  ls_size;
    logic [31:0] alu_addr, store_data, bus_rdata;
    logic        bus_ack, t_ack;

    logic        stall, ls_done, addr_misaligned, bus_error, bus_req, bus_we;
    logic [31:0] load_result, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        t_stall, t_done, t_mis, t_err, t_req, t_we;
    logic [31:0] t_result, t_addr, t_wdata;
    logic [3:0]  t_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .ls_valid(ls_valid), .mem_read(mem_read),
        .mem_write(mem_write), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .alu_addr(alu_addr), .store_data(store_data), .stall(stall),
        .ls_done(ls_done), .load_result(load_result),
        .addr_misaligned(addr_misaligned), .bus_error(bus_error),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(3), .TMO_W(8)) dut_tmo (
        .clk(clk), .rst_n(rst_n), .ls_valid(t_valid), .mem_read(mem_read),
        .mem_write(mem_write), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .alu_addr(alu_addr), .store_data(store_data), .stall(t_stall),
        .ls_done(t_done), .load_result(t_result),
        .addr_misaligned(t_mis), .bus_error(t_err),
        .bus_req(t_req), .bus_we(t_we), .bus_addr(t_addr),
        .bus_be(t_be), .bus_wdata(t_wdata), .bus_ack(t_ack),
        .bus_rdata(bus_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] sd);
        mem_read    = rd;
        mem_write   = wr;
        ls_size     = sz;
        ls_unsigned = uns;
        alu_addr    = addr;
        store_data  = sd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ls_valid = 1'b1; t_valid = 1'b0; bus_ack = 1'b0; t_ack = 1'b0;
        bus_rdata = 32'h0;
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        #12;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", bus_req); end
        total++; if (ls_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", ls_done); end
        total++; if ({bus_be, bus_addr, bus_wdata, load_result} !== 100'h0) begin bad++; $display("FAIL rst_regs got=%h exp=0", {bus_be, bus_addr, bus_wdata, load_result}); end
        ls_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word_store();
        present(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF);
        ls_valid = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ws_stall_c1 got=%0h exp=1", stall); end
        step();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ws_stall_c2 got=%0h exp=1", stall); end
        total++; if ({bus_req, bus_we, bus_be} !== 6'b11_1111) begin bad++; $display("FAIL ws_ctrl got=%b exp=111111", {bus_req, bus_we, bus_be}); end
        total++; if (bus_addr !== 32'h1000_0004) begin bad++; $display("FAIL ws_addr got=%h exp=10000004", bus_addr); end
        total++; if (bus_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ws_wdata got=%h exp=deadbeef", bus_wdata); end
        total++; if (ls_done !== 1'b0) begin bad++; $display("FAIL ws_early_done got=%0h exp=0", ls_done); end
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        step();
        bus_ack = 1'b0; ls_valid = 1'b0;
        total++; if ({ls_done, stall, bus_req} !== 3'b100) begin bad++; $display("FAIL ws_done got=%b exp=100", {ls_done, stall, bus_req}); end
        total++; if (load_result !== 32'h0) begin bad++; $display("FAIL ws_result got=%h exp=0", load_result); end
        step();
        total++; if (ls_done !== 1'b0) begin bad++; $display("FAIL ws_done_pulse got=%0h exp=0", ls_done); end
    endtask

    task automatic test_byte_load();
        logic [31:0] exp_res [2];
        exp_res[0] = 32'hFFFF_FF80;
        exp_res[1] = 32'h0000_0080;
        for (int u = 0; u < 2; u++) begin
            present(1'b1, 1'b0, 2'b00, u[0], 32'h2000_0003, 32'hFFFF_FFFF);
            ls_valid = 1'b1;
            step();
            total++; if ({bus_req, bus_we, bus_be} !== 6'b10_1000) begin bad++; $display("FAIL bl_ctrl[%0d] got=%b exp=101000", u, {bus_req, bus_we, bus_be}); end
            total++; if ({bus_addr, bus_wdata} !== {32'h2000_0000, 32'h0}) begin bad++; $display("FAIL bl_bus[%0d] got=%h", u, {bus_addr, bus_wdata}); end
            bus_ack = 1'b1; bus_rdata = 32'h80FF_FF7F;
            step();
            bus_ack = 1'b0; ls_valid = 1'b0;
            total++; if (ls_done !== 1'b1) begin bad++; $display("FAIL bl_done[%0d] got=%0h exp=1", u, ls_done); end
            total++; if (load_result !== exp_res[u]) begin bad++; $display("FAIL bl_result[%0d] got=%h exp=%h", u, load_result, exp_res[u]); end
            step();
        end
    endtask

    task automatic test_half_wait();
        int stall_cycles = 0;
        present(1'b1, 1'b0, 2'b01, 1'b0, 32'h3000_0002, 32'h0);
        ls_valid = 1'b1;
        #1;
        if (stall === 1'b1) stall_cycles++;
        step();
        for (int i = 0; i < 4; i++) begin
            if (stall === 1'b1) stall_cycles++;
            total++; if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, ls_done} !== {1'b1, 1'b0, 4'b1100, 32'h3000_0000, 32'h0, 1'b0}) begin
                bad++; $display("FAIL hw_stable[%0d] got=%b_%b_%b_%h_%h_%b", i, bus_req, bus_we, bus_be, bus_addr, bus_wdata, ls_done);
            end
            bus_rdata = 32'hAAAA_AAAA;
            step();
        end
        if (stall === 1'b1) stall_cycles++;
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL hw_req_w5 got=%0h exp=1", bus_req); end
        bus_ack = 1'b1; bus_rdata = 32'h8001_1234;
        step();
        bus_ack = 1'b0; ls_valid = 1'b0;
        total++; if (stall_cycles != 6) begin bad++; $display("FAIL hw_stall_len got=%0d exp=6", stall_cycles); end
        total++; if ({ls_done, stall} !== 2'b10) begin bad++; $display("FAIL hw_done got=%b exp=10", {ls_done, stall}); end
        total++; if (load_result !== 32'hFFFF_8001) begin bad++; $display("FAIL hw_result got=%h exp=ffff8001", load_result); end
        step();
    endtask

    task automatic test_misaligned();
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000_0002, 32'h0);
        ls_valid = 1'b1;
        bus_rdata = 32'h1234_5678;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ma_stall got=%0h exp=1", stall); end
        step();
        ls_valid = 1'b0;
        total++; if ({ls_done, addr_misaligned, bus_req, stall, bus_error} !== 5'b11000) begin bad++; $display("FAIL ma_flags got=%b exp=11000", {ls_done, addr_misaligned, bus_req, stall, bus_error}); end
        total++; if (load_result !== 32'h0) begin bad++; $display("FAIL ma_result got=%h exp=0", load_result); end
        step();
        total++; if ({ls_done, addr_misaligned} !== 2'b00) begin bad++; $display("FAIL ma_clear got=%b exp=00", {ls_done, addr_misaligned}); end
    endtask

    task automatic test_store_lanes();
        present(1'b0, 1'b1, 2'b01, 1'b0, 32'h7000_0006, 32'h1234_BEEF);
        ls_valid = 1'b1;
        step();
        total++; if ({bus_be, bus_wdata, bus_addr} !== {4'b1100, 32'hBEEF_BEEF, 32'h7000_0004}) begin bad++; $display("FAIL hs_lanes got=%b_%h_%h", bus_be, bus_wdata, bus_addr); end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        // Immediately present the next access after DONE.
        present(1'b0, 1'b1, 2'b00, 1'b0, 32'h7000_0001, 32'h0000_00A5);
        step();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL bs_accept got=%0h exp=1", stall); end
        step();
        total++; if ({bus_req, bus_be, bus_wdata} !== {1'b1, 4'b0010, 32'hA5A5_A5A5}) begin bad++; $display("FAIL bs_lanes got=%b_%b_%h", bus_req, bus_be, bus_wdata); end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0; ls_valid = 1'b0;
        total++; if (ls_done !== 1'b1) begin bad++; $display("FAIL bs_done got=%0h exp=1", ls_done); end
        step();
    endtask

    task automatic test_timeout();
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h5000_0008, 32'h0);
        t_valid = 1'b1;
        step();
        t_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if ({t_req, t_err, t_done} !== 3'b100) begin bad++; $display("FAIL to_wait[%0d] got=%b exp=100", i, {t_req, t_err, t_done}); end
            step();
        end
        total++; if ({t_req, t_err, t_done, t_stall} !== 4'b0110) begin bad++; $display("FAIL to_error got=%b exp=0110", {t_req, t_err, t_done, t_stall}); end
        total++; if (t_result !== 32'h0) begin bad++; $display("FAIL to_result got=%h exp=0", t_result); end
        step();
        total++; if ({t_err, t_done} !== 2'b00) begin bad++; $display("FAIL to_clear got=%b exp=00", {t_err, t_done}); end
        // Ack on the very cycle the timeout would fire: the ack wins.
        t_valid = 1'b1;
        step();
        t_valid = 1'b0;
        step();
        step();
        t_ack = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        t_ack = 1'b0;
        total++; if ({t_done, t_err} !== 2'b10) begin bad++; $display("FAIL race_flags got=%b exp=10", {t_done, t_err}); end
        total++; if (t_result !== 32'h1234_5678) begin bad++; $display("FAIL race_result got=%h exp=12345678", t_result); end
        step();
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h6000_0000, 32'h0);
        ls_valid = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++; if ({bus_req, stall} !== 2'b00) begin bad++; $display("FAIL rm_drop got=%b exp=00", {bus_req, stall}); end
        for (int i = 0; i < 3; i++) begin
            if (ls_done === 1'b1) done_seen++;
            step();
        end
        ls_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (ls_done === 1'b1) done_seen++;
            step();
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL rm_no_done got=%0d exp=0", done_seen); end
        present(1'b1, 1'b0, 2'b01, 1'b1, 32'h6000_0000, 32'h0);
        ls_valid = 1'b1;
        step();
        total++; if ({bus_req, bus_be} !== 5'b1_0011) begin bad++; $display("FAIL rm_new_req got=%b exp=10011", {bus_req, bus_be}); end
        bus_ack = 1'b1; bus_rdata = 32'h0000_9ABC;
        step();
        bus_ack = 1'b0; ls_valid = 1'b0;
        total++; if ({ls_done, load_result} !== {1'b1, 32'h0000_9ABC}) begin bad++; $display("FAIL rm_new_done got=%b_%h exp=1_00009abc", ls_done, load_result); end
        step();
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_wait();
        test_misaligned();
        test_store_lanes();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
